// File: rtl/vmicro16_halt_monitor_pkg.sv
// Shared definitions for the vmicro16 halt monitor: FSM state encoding and
// the helper that locates a channel inside a packed multi-channel bus.
package vmicro16_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } mon_state_e;

  // LSB position of channel 'ch' in a bus packed with channel 0 in the LSBs.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/vmicro16_halt_monitor_if.sv
// Stimulus/result bundle of the halt monitor. The master side is whatever
// drives the run (SoC wrapper or bench); the slave side is the monitor.
interface vmicro16_halt_monitor_if #(
  parameter int CORES      = 4,
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CW         = 17
);
  logic                           start;
  logic [CORES-1:0]               halt;
  logic [CHANNELS*DATA_WIDTH-1:0] obs;
  logic [CHANNELS*DATA_WIDTH-1:0] expected;
  logic [CHANNELS-1:0]            check_en;
  logic                           busy;
  logic                           done;
  logic                           pass;
  logic                           timed_out;
  logic [CHANNELS-1:0]            mismatch;
  logic [CHANNELS*DATA_WIDTH-1:0] captured;
  logic [CW-1:0]                  cycles;

  modport master (
    output start, halt, obs, expected, check_en,
    input  busy, done, pass, timed_out, mismatch, captured, cycles
  );

  modport slave (
    input  start, halt, obs, expected, check_en,
    output busy, done, pass, timed_out, mismatch, captured, cycles
  );
endinterface

// File: rtl/vmicro16_halt_monitor_cmp.sv
// Masked comparator for one result channel. Combinational; the parent
// registers the flag when it leaves COMPARE.
module vmicro16_halt_monitor_cmp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] obs_i,
  input  logic [DATA_WIDTH-1:0] expected_i,
  input  logic                  en_i,
  output logic                  mismatch_o
);
  assign mismatch_o = en_i & (obs_i != expected_i);
endmodule

// File: rtl/vmicro16_halt_monitor.sv
// Run-completion checker: arms on start, counts cycles until the cores halt
// (or the watchdog expires), waits a settle window, samples the result
// channels and compares them against expected values under a mask.
module vmicro16_halt_monitor
  import vmicro16_monitor_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int HALT_ALL   = 1,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 100000,
  parameter int CW         = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  vmicro16_halt_monitor_if.slave bus
);

  // Settle counter is at least one bit wide so SETTLE=0 still elaborates.
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] CYC_LAST    = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);

  mon_state_e                     state_q;
  logic [CW-1:0]                  cycles_q;
  logic [SW-1:0]                  settle_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           pass_q;
  logic                           timed_out_q;
  logic [CHANNELS-1:0]            mismatch_q;
  logic [CHANNELS*DATA_WIDTH-1:0] captured_q;
  logic                           hc_s;
  logic [CHANNELS-1:0]            cmp_mis_s;

  assign hc_s = (HALT_ALL != 0) ? (&bus.halt) : (|bus.halt);

  // The sample is taken on entry to COMPARE, so the verdict is computed
  // against the registered capture and always agrees with 'captured'.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    vmicro16_halt_monitor_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .obs_i      (captured_q[chan_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .expected_i (bus.expected[chan_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .en_i       (bus.check_en[i]),
      .mismatch_o (cmp_mis_s[i])
    );
  end

  // Run FSM with cycle/settle counters and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cycles_q    <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      mismatch_q  <= '0;
      captured_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q     <= ST_ARMED;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cycles_q    <= '0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            mismatch_q  <= '0;
            captured_q  <= '0;
          end
        end
        ST_ARMED: begin
          // Halt takes priority over a watchdog expiry in the same cycle;
          // the counter only advances while the run stays armed.
          if (hc_s) begin
            if (SETTLE == 0) begin
              state_q    <= ST_COMPARE;
              captured_q <= bus.obs;
            end else begin
              state_q  <= ST_SETTLE;
              settle_q <= SETTLE_LOAD;
            end
          end else if (cycles_q == CYC_LAST) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            timed_out_q <= 1'b1;
            pass_q      <= 1'b0;
            mismatch_q  <= '0;
            captured_q  <= bus.obs;
          end else begin
            cycles_q <= cycles_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          // Halt is treated as sticky here: hc dropping does not abort.
          if (settle_q == SW'(1)) begin
            state_q    <= ST_COMPARE;
            captured_q <= bus.obs;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        ST_COMPARE: begin
          state_q    <= ST_DONE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          mismatch_q <= cmp_mis_s;
          pass_q     <= ~|cmp_mis_s;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timed_out = timed_out_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.captured  = captured_q;
  assign bus.cycles    = cycles_q;

endmodule

// File: doc/vmicro16_halt_monitor.md
# vmicro16_halt_monitor

Synthesisable run-completion checker for vmicro16 multi-core SoC builds. Once armed, it counts cycles until a configurable halt condition across the cores, waits a settle window, then captures N observed result channels (GPIO/result buses) and compares each against an expected value under a per-channel enable mask. A cycle-count watchdog ends a run that never halts. The block sits beside the SoC in test builds and on-board self-test images. It replaces ad-hoc bench checks of a single GPIO value taken at halt.

## Interface

Parameters:
- `CORES`, 4, number of per-core halt inputs.
- `CHANNELS`, 2, number of observed result channels.
- `DATA_WIDTH`, 16, width of each channel.
- `HALT_ALL`, 1, halt mode. 1: all cores halted. 0: any core halted.
- `SETTLE`, 2, cycles to wait between halt detection and capture. 0 is legal.
- `TIMEOUT`, 100000, cycles in ARMED before the watchdog ends the run. Must be ≥1.
- `CW`, $clog2(TIMEOUT+1), derived cycle-counter width.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle arm pulse.
- `halt`  in  CORES  per-core halt flags.
- `obs`  in  CHANNELS*DATA_WIDTH  observed channels, packed; channel 0 is in the LSBs.
- `expected`  in  CHANNELS*DATA_WIDTH  expected values, packed the same way.
- `check_en`  in  CHANNELS  per-channel compare enable.
- `busy`  out  1  high in ARMED, SETTLE and COMPARE.
- `done`  out  1  high in DONE.
- `pass`  out  1  result verdict, valid while `done`.
- `timed_out`  out  1  watchdog fired, valid while `done`.
- `mismatch`  out  CHANNELS  per-channel failure flags, valid while `done`.
- `captured`  out  CHANNELS*DATA_WIDTH  sampled `obs`.
- `cycles`  out  CW  cycles spent in ARMED.

## Operation

Reset values: all outputs are 0 and the state is IDLE.

Halt condition `hc`:
- `HALT_ALL`=1: `&halt`.
- `HALT_ALL`=0: `|halt`.
- `hc` is level-sensitive.

State machine:
- IDLE: `start` → ARMED. `cycles`, `mismatch`, `pass`, `timed_out` and `captured` are cleared on that edge.
- ARMED: `cycles` increments every cycle.
  - `hc`=1 → SETTLE, or → COMPARE if `SETTLE`=0.
  - Otherwise, `cycles`==TIMEOUT-1 → DONE with `timed_out`=1, `pass`=0, `mismatch`=0, and `captured` = `obs` sampled on that edge.
  - `hc` and timeout in the same cycle: `hc` wins.
- SETTLE: a down-counter loaded with `SETTLE` decrements each cycle; at 1 → COMPARE. `hc` dropping during SETTLE does not abort the run (core halt is sticky).
- COMPARE (one cycle), → DONE:
  - `captured` ← `obs`.
  - `mismatch[i]` = `check_en[i]` & (obs_i != expected_i).
  - `pass` = ~|mismatch.
- DONE: outputs are held. `start` → ARMED with a fresh run (clears as in IDLE).

Other rules:
- `start` while `busy` is ignored.
- `check_en`=0 on every channel gives `pass`=1 on a halt-terminated run.
- `cycles` never wraps; the watchdog bounds it to TIMEOUT-1.
- Reset asserted mid-run forces IDLE and zeroes all outputs immediately (asynchronous). Deassertion takes effect on the next `clk` edge.

## Timing

- `start` at edge E0 → `busy`=1 after E0; the first counted cycle is E0+1.
- `hc` first sampled high at edge H:
  - SETTLE=0: COMPARE after H; `done` after H+1.
  - SETTLE=S: `done` after H+S+1.
  - `cycles` freezes at its value at H; `obs` is sampled at edge H+S.
- Timeout: `done`=1 after the edge on which `cycles`==TIMEOUT-1.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure

- Shared package `vmicro16_monitor_pkg`: state encoding (IDLE, ARMED, SETTLE, COMPARE, DONE) and the channel-slice helper function.
- Sub-module `vmicro16_halt_monitor_cmp`: per-channel masked comparator, generated CHANNELS times. It is purely combinational and its result is registered in the parent.
- The parent holds the FSM, the cycle and settle counters, and the result registers.

## Test plan

- CORES=1, CHANNELS=1: `expected`=16'h7008, `check_en`=1, pulse `start`, drive `obs`=16'h7008, raise `halt` at cycle 50 → `done`=1, `pass`=1, `cycles`=50, `captured`=16'h7008.
- CHANNELS=2: ch1 observes 16'h1234, expected 16'h1235.
  - `check_en`=2'b11 → `mismatch`=2'b10, `pass`=0.
  - Rerun with `check_en`=2'b01 → `pass`=1.
- HALT_ALL=1, CORES=4: `halt` goes 4'b0111 and is held for 20 cycles, then 4'b1111 → no capture before the full mask. Same stimulus with HALT_ALL=0 → capture after the first halted core.
- TIMEOUT=64, `halt` never set → `done` after 64 counted cycles with `timed_out`=1, `pass`=0, `cycles`=63. Separately, raising `hc` on exactly cycle 63 → normal capture with `timed_out`=0.
- SETTLE=3, `obs` changes on the 2nd settle cycle → `captured` holds the new value.
- `start` pulsed while busy → run unaffected. `reset` pulled low in SETTLE → all outputs are 0 immediately. A subsequent `start` completes normally.
